uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_rx_fifo.sv | 54 +++++
 rtl/uart_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_rx.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the parity
// helper used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Parity bit a transmitter appends for the given data and parity sense.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic even);
        return even ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side bus of the UART receiver: received byte, status flags and pop strobe.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_busy;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;
    logic              rd_en;

    modport master (
        output rx_data, rx_valid, rx_busy, parity_err, frame_err, overrun,
        input  rd_en
    );

    modport slave (
        input  rx_data, rx_valid, rx_busy, parity_err, frame_err, overrun,
        output rd_en
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes with their error flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the read side masks it while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity, one stop bit.
// Define UART_RX_FIFO_EN to buffer bytes in a FIFO_DEPTH-entry FIFO popped by rd_en.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       parity_en,
    input  logic       even_parity,
    uart_rx_if.master  bus
);

    if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 1024) begin : g_bad_cpb
        $error("uart_rx: CLKS_PER_BIT out of range");
    end
    if (FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx: FIFO_DEPTH must be a power of two");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_meta, rx_s, rx_s_d;
    logic fall;

    rx_state_t         state, state_next;
    logic [CNT_W-1:0]  baud_cnt, cnt_next;
    logic [2:0]        bit_cnt, bit_next;
    logic [DATA_W-1:0] shreg;
    logic              par_en_q, even_q, par_err_q;
    logic              tick, latch_cfg, shift_en, par_sample, stop_sample;

    // Synchronizer; rx_s_d doubles as the edge-detect history and as the sample
    // point, so that with CLKS_PER_BIT=1 the start bit is still visible in START.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign fall = rx_s_d & ~rx_s;
    assign tick = (baud_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            par_en_q <= 1'b0;
            even_q   <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= cnt_next;
            bit_cnt  <= bit_next;
            if (latch_cfg) begin
                par_en_q <= parity_en;
                even_q   <= even_parity;
            end
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = tick ? baud_cnt : baud_cnt - 1'b1;
        bit_next    = bit_cnt;
        latch_cfg   = 1'b0;
        shift_en    = 1'b0;
        par_sample  = 1'b0;
        stop_sample = 1'b0;
        case (state)
            IDLE: if (fall) begin
                state_next = START;
                cnt_next   = HALF_BIT;
                latch_cfg  = 1'b1;
            end
            START: if (tick) begin
                state_next = rx_s_d ? IDLE : DATA;
                cnt_next   = FULL_BIT;
                bit_next   = 3'd0;
            end
            DATA: if (tick) begin
                cnt_next = FULL_BIT;
                shift_en = 1'b1;
                bit_next = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_next = par_en_q ? PARITY : STOP;
            end
            PARITY: if (tick) begin
                cnt_next   = FULL_BIT;
                par_sample = 1'b1;
                state_next = STOP;
            end
            STOP: if (tick) begin
                stop_sample = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (shift_en)   shreg <= {rx_s_d, shreg[DATA_W-1:1]};
        if (latch_cfg)  par_err_q <= 1'b0;
        if (par_sample) par_err_q <= rx_s_d ^ parity_bit(shreg, even_q);
    end

    assign bus.rx_busy = ((state != IDLE) | fall) & ~stop_sample;

    // ---- stage p1: delivery of the completed frame ----
`ifdef UART_RX_FIFO_EN
    logic              fifo_empty, fifo_full, fifo_pop;
    logic [DATA_W+1:0] fifo_dout;
    logic              overrun_p1;

    assign fifo_pop = bus.rd_en & ~fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (stop_sample),
        .din   ({par_err_q, ~rx_s_d, shreg}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst)                                         overrun_p1 <= 1'b0;
        else if (stop_sample & fifo_full & ~fifo_pop)    overrun_p1 <= 1'b1;
    end

    assign bus.rx_valid   = ~fifo_empty;
    assign bus.rx_data    = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
    assign bus.frame_err  = ~fifo_empty & fifo_dout[DATA_W];
    assign bus.parity_err = ~fifo_empty & fifo_dout[DATA_W+1];
    assign bus.overrun    = overrun_p1;
`else
    logic [DATA_W-1:0] data_p1;
    logic              vld_p1, perr_p1, ferr_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            perr_p1 <= 1'b0;
            ferr_p1 <= 1'b0;
        end else begin
            vld_p1 <= stop_sample;
            if (stop_sample) begin
                data_p1 <= shreg;
                perr_p1 <= par_err_q;
                ferr_p1 <= ~rx_s_d;
            end
        end
    end

    assign bus.rx_valid   = vld_p1;
    assign bus.rx_data    = data_p1;
    assign bus.parity_err = perr_p1;
    assign bus.frame_err  = ferr_p1;
    assign bus.overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one receiver at CLKS_PER_BIT=1 and one at 16, frames driven
// bit by bit, a queue of expected bytes checked on every delivery.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx1 = 1'b1;
    logic rx16 = 1'b1;
    logic pen = 1'b0;
    logic evp = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    exp_t q1[$];
    exp_t q16[$];
    exp_t e1, e16, last1, last16;
    int   nv1 = 0, nv16 = 0, t_valid1 = 0;
    logic chk1 = 1'b1, chk16 = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_if bus1();
    uart_rx_if bus16();

    uart_rx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .rx(rx1), .parity_en(pen), .even_parity(evp), .bus(bus1)
    );
    uart_rx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) u16 (
        .clk(clk), .rst(rst), .rx(rx16), .parity_en(pen), .even_parity(evp), .bus(bus16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every delivered byte must match the oldest frame the model expects.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus1.rx_valid && chk1) begin
                nv1++;
                t_valid1 = cyc;
                last1 = '{bus1.rx_data, bus1.parity_err, bus1.frame_err};
                if (q1.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL u1 unexpected rx_valid: got data 0x%0h, expected no delivery", bus1.rx_data);
                end else begin
                    e1 = q1.pop_front();
                    check("u1 rx_data", bus1.rx_data, e1.d);
                    check("u1 parity_err", bus1.parity_err, e1.pe);
                    check("u1 frame_err", bus1.frame_err, e1.fe);
                end
            end
            if (bus16.rx_valid && chk16) begin
                nv16++;
                last16 = '{bus16.rx_data, bus16.parity_err, bus16.frame_err};
                if (q16.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL u16 unexpected rx_valid: got data 0x%0h, expected no delivery", bus16.rx_data);
                end else begin
                    e16 = q16.pop_front();
                    check("u16 rx_data", bus16.rx_data, e16.d);
                    check("u16 parity_err", bus16.parity_err, e16.pe);
                    check("u16 frame_err", bus16.frame_err, e16.fe);
                end
            end
        end
    end

    task automatic hold(input bit w16, input logic v, input int n);
        if (w16) rx16 = v; else rx1 = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit w16, input logic [7:0] d, input logic pbit,
                        input logic stop, input bit expect_it);
        int   cpb;
        exp_t e;
        cpb = w16 ? 16 : 1;
        if (expect_it) begin
            e.d  = d;
            e.pe = pen && (pbit != (evp ? ^d : ~^d));
            e.fe = !stop;
            if (w16) q16.push_back(e); else q1.push_back(e);
        end
        hold(w16, 1'b0, cpb);
        for (int i = 0; i < 8; i++) hold(w16, d[i], cpb);
        if (pen) hold(w16, pbit, cpb);
        hold(w16, stop, cpb);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_start;
        int nv_before;
        bus1.rd_en  = 1'b1;
        bus16.rd_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset rx_data", bus16.rx_data, 8'h00);
        check("reset rx_valid", bus16.rx_valid, 1'b0);
        check("reset rx_busy", bus16.rx_busy, 1'b0);
        check("reset parity_err", bus16.parity_err, 1'b0);
        check("reset frame_err", bus16.frame_err, 1'b0);
        check("reset overrun", bus16.overrun, 1'b0);
        check("reset u1 rx_valid", bus1.rx_valid, 1'b0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // CLKS_PER_BIT=1, no parity: 0xA5, first sampling edge N, delivery at N+12
        pen = 1'b0;
        t_start = cyc;
        send(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1);
        hold(1'b0, 1'b1, 20);
        check("u1 A5 latency", t_valid1, t_start + 1 + 12);
        check("u1 A5 data", last1.d, 8'hA5);
        check("u1 A5 errors", {last1.pe, last1.fe}, 2'b00);

        // CLKS_PER_BIT=1 with parity adds one bit time
        pen = 1'b1; evp = 1'b1;
        t_start = cyc;
        send(1'b0, 8'h07, 1'b1, 1'b1, 1'b1);
        hold(1'b0, 1'b1, 20);
        check("u1 parity latency", t_valid1, t_start + 1 + 13);

        // CLKS_PER_BIT=16, even parity on 0x07 (three ones -> parity bit 1)
        send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        hold(1'b1, 1'b1, 40);
        check("u16 07 good parity", last16.pe, 1'b0);
        send(1'b1, 8'h07, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 1'b1, 40);
        check("u16 07 bad parity", last16.pe, 1'b1);
        check("u16 07 data", last16.d, 8'h07);

        // Frame error, then line stuck low must not retrigger
        pen = 1'b0;
        nv_before = nv16;
        send(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        hold(1'b1, 1'b0, 64);
        check("u16 3C data", last16.d, 8'h3C);
        check("u16 3C frame_err", last16.fe, 1'b1);
        check("u16 stuck low deliveries", nv16 - nv_before, 1);
        hold(1'b1, 1'b1, 40);

        // 4-cycle glitch: busy while START checks, then back to idle
        nv_before = nv16;
        hold(1'b1, 1'b0, 4);
        hold(1'b1, 1'b1, 2);
        check("glitch busy", bus16.rx_busy, 1'b1);
        hold(1'b1, 1'b1, 14);
        check("glitch busy cleared", bus16.rx_busy, 1'b0);
        hold(1'b1, 1'b1, 20);
        check("glitch deliveries", nv16 - nv_before, 0);

        // Reset in the middle of data bit 3 of 0xFF
        nv_before = nv16;
        hold(1'b1, 1'b0, 16);
        for (int i = 0; i < 3; i++) hold(1'b1, 1'b1, 16);
        hold(1'b1, 1'b1, 8);
        rst = 1'b1;
        hold(1'b1, 1'b1, 2);
        check("midrst outputs", {bus16.rx_data, bus16.rx_valid, bus16.rx_busy,
                                 bus16.parity_err, bus16.frame_err, bus16.overrun}, 13'h0);
        rst = 1'b0;
        hold(1'b1, 1'b1, 10);
        check("midrst deliveries", nv16 - nv_before, 0);
        send(1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
        hold(1'b1, 1'b1, 40);
        check("after rst 55 data", last16.d, 8'h55);

`ifdef UART_RX_FIFO_EN
        // Five frames into a four-entry FIFO with no pops
        chk16 = 1'b0;
        bus16.rd_en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
            hold(1'b1, 1'b1, 16);
        end
        check("fifo overrun", bus16.overrun, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check("fifo head valid", bus16.rx_valid, 1'b1);
            check("fifo head data", bus16.rx_data, 8'(i));
            bus16.rd_en = 1'b1;
            @(posedge clk);
            #1;
            bus16.rd_en = 1'b0;
        end
        check("fifo drained", bus16.rx_valid, 1'b0);
        rst = 1'b1;
        hold(1'b1, 1'b1, 2);
        rst = 1'b0;
        hold(1'b1, 1'b1, 2);
        check("fifo overrun cleared", bus16.overrun, 1'b0);
        bus16.rd_en = 1'b1;
        chk16 = 1'b1;
`else
        // rd_en has no effect: each byte is one rx_valid pulse
        bus16.rd_en = 1'b0;
        nv_before = nv16;
        send(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1);
        hold(1'b1, 1'b1, 40);
        check("pulse once without rd_en", nv16 - nv_before, 1);
        check("overrun tied low", bus16.overrun, 1'b0);
        bus16.rd_en = 1'b1;
`endif

        check("u1 model drained", q1.size(), 0);
        check("u16 model drained", q16.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
